// File: rtl/key_pkg.sv
`default_nettype none
//------------------------------------------------------------------
// key_pkg : shared types and helpers for the key front-end
// Rev 1.0
//------------------------------------------------------------------
package key_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } key_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_chain.sv
`default_nettype none
//------------------------------------------------------------------
// sync_chain : multi-flop synchronizer for an asynchronous 1-bit input
// Rev 1.0
//------------------------------------------------------------------
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/key_pulse_gen.sv
`default_nettype none
//------------------------------------------------------------------
// key_pulse_gen : key synchronizer, debouncer and press/repeat strobe
// Rev 1.0
//------------------------------------------------------------------
module key_pulse_gen
  import key_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ACTIVE_LOW_KEY  = 1,
  parameter int REPEAT_EN       = 0,
  parameter int HOLD_CYCLES     = 1000,
  parameter int REPEAT_CYCLES   = 250
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic key_raw,
  output logic level,
  output logic pulse
);

  localparam int c_db_w = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int c_rp_w = $clog2(max_int(HOLD_CYCLES, REPEAT_CYCLES) + 1);

  localparam logic [c_db_w-1:0] c_db_last   = c_db_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_rp_w-1:0] c_hold_last = c_rp_w'(HOLD_CYCLES - 1);
  localparam logic [c_rp_w-1:0] c_rep_last  = c_rp_w'(REPEAT_CYCLES - 1);
  localparam logic              c_key_inv   = (ACTIVE_LOW_KEY != 0);
  localparam logic              c_rep_en    = (REPEAT_EN != 0);

  logic              w_pressed_raw;
  logic              w_pressed_s;
  logic [c_db_w-1:0] r_db_cnt;
  logic              r_db_level;
  key_state_t        r_state;
  key_state_t        w_state_next;
  logic [c_rp_w-1:0] r_rp_cnt;
  logic [c_rp_w-1:0] w_rp_cnt_next;
  logic              r_pulse;
  logic              w_pulse_next;
  logic              r_level;

  assign w_pressed_raw = key_raw ^ c_key_inv;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .d       (w_pressed_raw),
    .q       (w_pressed_s)
  );

  // A single agreeing sample restarts the stability count.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_db_cnt   <= '0;
      r_db_level <= 1'b0;
    end else if (w_pressed_s == r_db_level) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == c_db_last) begin
      r_db_level <= w_pressed_s;
      r_db_cnt   <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + c_db_w'(1);
    end
  end

  // level is re-registered so it rises on the same edge as the press pulse.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state  <= IDLE;
      r_rp_cnt <= '0;
      r_pulse  <= 1'b0;
      r_level  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_rp_cnt <= w_rp_cnt_next;
      r_pulse  <= w_pulse_next;
      r_level  <= r_db_level;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_rp_cnt_next = r_rp_cnt;
    if (!r_db_level) begin
      w_state_next  = IDLE;
      w_rp_cnt_next = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_next  = HOLD;
          w_rp_cnt_next = '0;
        end
        HOLD: begin
          if (r_rp_cnt == c_hold_last) begin
            w_rp_cnt_next = '0;
            if (c_rep_en) begin
              w_state_next = REPEAT;
            end
          end else begin
            w_rp_cnt_next = r_rp_cnt + c_rp_w'(1);
          end
        end
        REPEAT: begin
          if (r_rp_cnt == c_rep_last) begin
            w_rp_cnt_next = '0;
          end else begin
            w_rp_cnt_next = r_rp_cnt + c_rp_w'(1);
          end
        end
        default: begin
          w_state_next  = IDLE;
          w_rp_cnt_next = '0;
        end
      endcase
    end
  end

  // Gated by the previous pulse so short timer settings never yield back-to-back strobes.
  always_comb begin
    w_pulse_next = 1'b0;
    if (r_db_level) begin
      case (r_state)
        IDLE:    w_pulse_next = 1'b1;
        HOLD:    w_pulse_next = c_rep_en && (r_rp_cnt == c_hold_last);
        REPEAT:  w_pulse_next = (r_rp_cnt == c_rep_last);
        default: w_pulse_next = 1'b0;
      endcase
    end
    w_pulse_next = w_pulse_next & ~r_pulse;
  end

  assign level = r_level;
  assign pulse = r_pulse;

endmodule
`default_nettype wire

// File: tb/tb_key_pulse_gen.sv
`default_nettype none
//------------------------------------------------------------------
// tb_key_pulse_gen : scoreboard bench, repeat-off and repeat-on instances
// Rev 1.0
//------------------------------------------------------------------
module tb_key_pulse_gen;

  localparam int LAT  = 6;   // sync stages + debounce cycles
  localparam int HOLD = 10;
  localparam int REP  = 5;

  logic Clk     = 1'b0;
  logic Reset_n = 1'b0;
  logic key_raw = 1'b1;
  logic level_nr, pulse_nr, level_rp, pulse_rp;
  logic [2:0] cnt3;

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;
  int q_nr[$];
  int q_rp[$];

  key_pulse_gen #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW_KEY(1),
    .REPEAT_EN(0), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
  ) dut_nr (
    .Clk(Clk), .Reset_n(Reset_n), .key_raw(key_raw), .level(level_nr), .pulse(pulse_nr)
  );

  key_pulse_gen #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW_KEY(1),
    .REPEAT_EN(1), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
  ) dut_rp (
    .Clk(Clk), .Reset_n(Reset_n), .key_raw(key_raw), .level(level_rp), .pulse(pulse_rp)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Lab 3-bit counter enabled by the non-repeating instance.
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) cnt3 <= 3'd0;
    else if (pulse_nr) cnt3 <= cnt3 + 3'd1;
  end

  // Scoreboard: each queue holds the edge numbers after which a pulse is due.
  always @(negedge Clk) begin
    if (q_nr.size() > 0 && q_nr[0] == cyc) begin
      n_checks++;
      if (pulse_nr !== 1'b1) begin
        n_fail++;
        $display("FAIL pulse_nr edge %0d: got %b, want 1", cyc, pulse_nr);
      end
      void'(q_nr.pop_front());
    end else if (pulse_nr !== 1'b0) begin
      n_checks++;
      n_fail++;
      $display("FAIL pulse_nr unexpected edge %0d: got %b, want 0", cyc, pulse_nr);
    end
    if (q_rp.size() > 0 && q_rp[0] == cyc) begin
      n_checks++;
      if (pulse_rp !== 1'b1) begin
        n_fail++;
        $display("FAIL pulse_rp edge %0d: got %b, want 1", cyc, pulse_rp);
      end
      void'(q_rp.pop_front());
    end else if (pulse_rp !== 1'b0) begin
      n_checks++;
      n_fail++;
      $display("FAIL pulse_rp unexpected edge %0d: got %b, want 0", cyc, pulse_rp);
    end
  end

  // Model: press pulse at p, repeats while the FSM still sees level high (edge <= last_hi).
  task automatic push_exp(input int p, input int last_hi);
    q_nr.push_back(p);
    q_rp.push_back(p);
    for (int t = p + HOLD; t <= last_hi; t += REP) q_rp.push_back(t);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge Clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge Clk);
    n_checks += 2;
    if (level_nr !== 1'b0 || pulse_nr !== 1'b0) begin
      n_fail++; $display("FAIL reset_nr: got level=%b pulse=%b, want 0 0", level_nr, pulse_nr);
    end
    if (level_rp !== 1'b0 || pulse_rp !== 1'b0) begin
      n_fail++; $display("FAIL reset_rp: got level=%b pulse=%b, want 0 0", level_rp, pulse_rp);
    end
    Reset_n = 1'b1;
    repeat (10) @(negedge Clk);
    n_checks++;
    if (level_nr !== 1'b0 || level_rp !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: got %b %b, want 0 0", level_nr, level_rp);
    end
  endtask

  task automatic test_clean_press;
    int e0, rel;
    key_raw = 1'b0;
    e0 = cyc + 1;
    rel = e0 + 20;
    push_exp(e0 + LAT, rel + LAT - 1);
    wait_until(e0 + LAT - 1);
    n_checks++;
    if (level_nr !== 1'b0) begin n_fail++; $display("FAIL press_early: level got %b, want 0", level_nr); end
    wait_until(e0 + LAT);
    n_checks++;
    if (level_nr !== 1'b1 || level_rp !== 1'b1) begin
      n_fail++; $display("FAIL press_level: got %b %b, want 1 1", level_nr, level_rp);
    end
    wait_until(e0 + LAT + 1);
    n_checks++;
    if (pulse_nr !== 1'b0) begin n_fail++; $display("FAIL pulse_width: got %b, want 0", pulse_nr); end
    wait_until(rel - 1);
    key_raw = 1'b1;
    wait_until(rel + LAT - 1);
    n_checks++;
    if (level_nr !== 1'b1) begin n_fail++; $display("FAIL release_early: level got %b, want 1", level_nr); end
    wait_until(rel + LAT);
    n_checks++;
    if (level_nr !== 1'b0 || level_rp !== 1'b0) begin
      n_fail++; $display("FAIL release_level: got %b %b, want 0 0", level_nr, level_rp);
    end
    wait_until(rel + 12);
    n_checks++;
    if (q_nr.size() != 0 || q_rp.size() != 0) begin
      n_fail++; $display("FAIL clean_missing: pending %0d %0d, want 0 0", q_nr.size(), q_rp.size());
    end
  endtask

  task automatic test_bounce;
    int f, rel;
    for (int k = 0; k < 6; k++) begin
      key_raw = k[0];
      repeat (2) @(negedge Clk);
    end
    n_checks++;
    if (level_nr !== 1'b0 || level_rp !== 1'b0) begin
      n_fail++; $display("FAIL bounce_level: got %b %b, want 0 0", level_nr, level_rp);
    end
    key_raw = 1'b0;
    f = cyc + 1;
    rel = f + 12;
    push_exp(f + LAT, rel + LAT - 1);
    wait_until(f + LAT);
    n_checks++;
    if (level_nr !== 1'b1) begin n_fail++; $display("FAIL bounce_settle: level got %b, want 1", level_nr); end
    wait_until(rel - 1);
    key_raw = 1'b1;
    wait_until(rel + LAT);
    n_checks++;
    if (level_rp !== 1'b0) begin n_fail++; $display("FAIL bounce_release: level got %b, want 0", level_rp); end
    wait_until(rel + 12);
    n_checks++;
    if (q_nr.size() != 0 || q_rp.size() != 0) begin
      n_fail++; $display("FAIL bounce_missing: pending %0d %0d, want 0 0", q_nr.size(), q_rp.size());
    end
  endtask

  task automatic test_auto_repeat;
    int e0, rel;
    key_raw = 1'b0;
    e0 = cyc + 1;
    rel = e0 + 30;
    push_exp(e0 + LAT, rel + LAT - 1);
    wait_until(e0 + 16);
    n_checks++;
    if (pulse_rp !== 1'b1) begin n_fail++; $display("FAIL first_repeat: got %b, want 1", pulse_rp); end
    wait_until(rel - 1);
    key_raw = 1'b1;
    wait_until(rel + 12);
    n_checks++;
    if (q_nr.size() != 0 || q_rp.size() != 0) begin
      n_fail++; $display("FAIL repeat_missing: pending %0d %0d, want 0 0", q_nr.size(), q_rp.size());
    end
  endtask

  task automatic test_reset_mid_repeat;
    int e0, e1, rel;
    key_raw = 1'b0;
    e0 = cyc + 1;
    q_nr.push_back(e0 + LAT);
    q_rp.push_back(e0 + LAT);
    q_rp.push_back(e0 + LAT + HOLD);
    wait_until(e0 + 18);
    n_checks++;
    if (level_rp !== 1'b1) begin n_fail++; $display("FAIL pre_reset_level: got %b, want 1", level_rp); end
    #2 Reset_n = 1'b0;
    #1;
    n_checks += 2;
    if (level_nr !== 1'b0 || pulse_nr !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_nr: got %b %b, want 0 0", level_nr, pulse_nr);
    end
    if (level_rp !== 1'b0 || pulse_rp !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_rp: got %b %b, want 0 0", level_rp, pulse_rp);
    end
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    e1 = cyc + 1;
    rel = e1 + 12;
    push_exp(e1 + LAT, rel + LAT - 1);
    wait_until(e1 + LAT - 1);
    n_checks++;
    if (level_rp !== 1'b0) begin n_fail++; $display("FAIL post_reset_early: level got %b, want 0", level_rp); end
    wait_until(e1 + LAT);
    n_checks++;
    if (level_rp !== 1'b1) begin n_fail++; $display("FAIL post_reset_level: got %b, want 1", level_rp); end
    wait_until(rel - 1);
    key_raw = 1'b1;
    wait_until(rel + 12);
    n_checks++;
    if (q_nr.size() != 0 || q_rp.size() != 0) begin
      n_fail++; $display("FAIL reset_missing: pending %0d %0d, want 0 0", q_nr.size(), q_rp.size());
    end
  endtask

  task automatic test_glitch;
    int e0, rel;
    key_raw = 1'b0;
    repeat (3) @(negedge Clk);
    key_raw = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge Clk);
      n_checks++;
      if (level_nr !== 1'b0 || level_rp !== 1'b0) begin
        n_fail++; $display("FAIL press_glitch: got %b %b, want 0 0", level_nr, level_rp);
      end
    end
    key_raw = 1'b0;
    e0 = cyc + 1;
    rel = e0 + 25;
    push_exp(e0 + LAT, rel + LAT - 1);
    wait_until(e0 + 11);
    key_raw = 1'b1;
    wait_until(e0 + 14);
    key_raw = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge Clk);
      n_checks++;
      if (level_rp !== 1'b1) begin n_fail++; $display("FAIL release_glitch: level got %b, want 1", level_rp); end
    end
    wait_until(rel - 1);
    key_raw = 1'b1;
    wait_until(rel + 12);
    n_checks++;
    if (q_nr.size() != 0 || q_rp.size() != 0) begin
      n_fail++; $display("FAIL glitch_missing: pending %0d %0d, want 0 0", q_nr.size(), q_rp.size());
    end
  endtask

  task automatic test_counter_wrap;
    int e0;
    logic [2:0] exp_cnt;
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    n_checks++;
    if (cnt3 !== 3'd0) begin n_fail++; $display("FAIL count_start: got %0d, want 0", cnt3); end
    exp_cnt = 3'd0;
    for (int i = 0; i < 9; i++) begin
      key_raw = 1'b0;
      e0 = cyc + 1;
      push_exp(e0 + LAT, e0 + 8 + LAT - 1);
      wait_until(e0 + 7);
      key_raw = 1'b1;
      wait_until(e0 + 18);
      exp_cnt = exp_cnt + 3'd1;
      n_checks++;
      if (cnt3 !== exp_cnt) begin
        n_fail++; $display("FAIL count_press%0d: got %0d, want %0d", i, cnt3, exp_cnt);
      end
    end
    n_checks++;
    if (q_nr.size() != 0 || q_rp.size() != 0) begin
      n_fail++; $display("FAIL count_missing: pending %0d %0d, want 0 0", q_nr.size(), q_rp.size());
    end
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_clean_press;
    test_bounce;
    test_auto_repeat;
    test_reset_mid_repeat;
    test_glitch;
    test_counter_wrap;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/key_pulse_gen.md
# key_pulse_gen

Front-end conditioner for a push-button key: synchronizes the raw asynchronous key input, debounces it, and emits single-cycle `pulse` strobes (one per press, plus optional auto-repeat while held). `pulse` drives the `enable` input of the lab 3-bit counter directly, so each physical press advances the count by exactly one.

## Interface
- `SYNC_STAGES`, 2: synchronizer flop count; ≥2.
- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles required to change the debounced level; ≥1.
- `ACTIVE_LOW_KEY`, 1: 1 means raw key reads 0 when pressed (board KEY convention).
- `REPEAT_EN`, 0: 1 enables auto-repeat while held.
- `HOLD_CYCLES`, 1000: cycles from the first pulse to the first repeat pulse; ≥1.
- `REPEAT_CYCLES`, 250: cycles between successive repeat pulses; ≥1.
- `Clk` in 1: sole clock; all state updates on rising edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `key_raw` in 1: raw asynchronous key input, polarity per `ACTIVE_LOW_KEY`.
- `level` out 1: debounced key state, 1 = pressed.
- `pulse` out 1: one-cycle strobe per accepted press/repeat.

## Operation
- Normalize: `pressed_raw = key_raw ^ ACTIVE_LOW_KEY`; pass through `SYNC_STAGES` flops → `pressed_s`. Sync flops reset to 0 (released).
- Debounce: counter `db_cnt`, width `$clog2(DEBOUNCE_CYCLES+1)`. Each cycle: if `pressed_s == level`, `db_cnt <= 0`; else if `db_cnt == DEBOUNCE_CYCLES-1`, `level <= pressed_s`, `db_cnt <= 0`; else `db_cnt <= db_cnt+1`. Any single agreeing cycle restarts the count.
- FSM (`IDLE`, `HOLD`, `REPEAT`), repeat timer `rp_cnt` sized for `max(HOLD_CYCLES, REPEAT_CYCLES)`:
  - `IDLE`: on level 0→1 transition edge → `pulse` 1 next cycle, `rp_cnt <= 0`, go `HOLD` (if `REPEAT_EN`=0 the FSM still tracks `HOLD` but never leaves it until release).
  - `HOLD`: `rp_cnt` increments each cycle while `level`=1; when `REPEAT_EN` and `rp_cnt == HOLD_CYCLES-1` → pulse, `rp_cnt <= 0`, go `REPEAT`.
  - `REPEAT`: same, terminal count `REPEAT_CYCLES-1`, stays in `REPEAT`.
  - Any state: `level`=0 → `IDLE`, `rp_cnt <= 0`, no pulse.
- Release never produces a pulse. A level rise and a repeat expiry cannot coincide (repeat requires `level` already 1).
- Glitches (either polarity) shorter than `DEBOUNCE_CYCLES` synchronized cycles have no effect on `level` or `pulse`.
- `pulse` is never high two consecutive cycles.

## Timing
- Reset (asynchronous, any time incl. mid-count or mid-repeat): `level`=0, `pulse`=0, sync flops 0, `db_cnt`=0, `rp_cnt`=0, state `IDLE`. Release of `Reset_n` is synchronous to `Clk`; a key held through reset produces a fresh press pulse after full latency.
- Press latency: key stable pressed from edge 0 (first sampling edge) → `level` and `pulse` both rise after edge `SYNC_STAGES + DEBOUNCE_CYCLES`; `pulse` high exactly one cycle.
- Release latency: `level` falls after edge `SYNC_STAGES + DEBOUNCE_CYCLES` counted from the first released sample.
- Repeat: first repeat pulse `HOLD_CYCLES` cycles after the initial pulse, then every `REPEAT_CYCLES` cycles while `level`=1.
- All outputs registered; no combinational path from `key_raw`.

## Structure
- Package `key_pkg`: `typedef enum logic [1:0] {IDLE, HOLD, REPEAT} key_state_t`.
- Sub-module `sync_chain` (parameter `STAGES`, async active-low reset to 0): the synchronizer, reusable for other board inputs.
- Debounce counter and FSM live in `key_pulse_gen`.

## Test plan
Bench parameters: `SYNC_STAGES`=2, `DEBOUNCE_CYCLES`=4, `ACTIVE_LOW_KEY`=1, `HOLD_CYCLES`=10, `REPEAT_CYCLES`=5.
- Clean press (`key_raw` 1→0 before edge 0, held 20 cycles, `REPEAT_EN`=0) → `level`,`pulse` rise after edge 6, `pulse` low after edge 7, exactly one pulse; release → `level` 0 after 6 edges, no pulse.
- Bounce: `key_raw` toggles 0/1 every 2 cycles for 12 cycles then held 0 → no pulse during bouncing, single pulse 6 edges after the final transition.
- Auto-repeat (`REPEAT_EN`=1, held 30 cycles after press) → pulses after edges 6, 16, 21, 26, 31; none on release.
- Reset mid-repeat: assert `Reset_n`=0 between edges 18 and 19 → `level`,`pulse` 0 immediately; deassert with key still held → new pulse 6 edges after the first post-reset edge.
- 3-cycle glitch on idle key → `level` and `pulse` stay 0; chained with the 3-bit counter, 9 clean presses → count wraps 0→…→7→0→1.
